// File: rtl/hazard_stall_if.sv
// hazard_stall_if: hazard inputs and stall/flush/perf outputs of the pipeline stall sequencer
interface hazard_stall_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             id_uses_rs_i;
   logic             id_uses_rt_i;
   logic             ex_mem_read_i;
   logic [4:0]       ex_rt_i;
   logic             icache_ready_i;
   logic             dcache_req_i;
   logic             dcache_ready_i;
   logic             ex_mispredict_i;
   logic             perf_clr_i;
   logic             pc_stall_o;
   logic             ifid_stall_o;
   logic             idex_stall_o;
   logic             exmem_stall_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             memwb_flush_o;
   logic             dstall_timeout_o;
   logic [CNT_W-1:0] cnt_load_use_o;
   logic [CNT_W-1:0] cnt_dmiss_o;
   logic [CNT_W-1:0] cnt_imiss_o;
   logic [CNT_W-1:0] cnt_flush_o;
   modport master (
      output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
             icache_ready_i, dcache_req_i, dcache_ready_i, ex_mispredict_i, perf_clr_i,
      input  pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o, ifid_flush_o,
             idex_flush_o, memwb_flush_o, dstall_timeout_o,
             cnt_load_use_o, cnt_dmiss_o, cnt_imiss_o, cnt_flush_o
   );
   modport slave (
      input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
             icache_ready_i, dcache_req_i, dcache_ready_i, ex_mispredict_i, perf_clr_i,
      output pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o, ifid_flush_o,
             idex_flush_o, memwb_flush_o, dstall_timeout_o,
             cnt_load_use_o, cnt_dmiss_o, cnt_imiss_o, cnt_flush_o
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-stage stall/flush sequencing for load-use, cache-miss and mispredict hazards
module hazard_stall_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input logic           clk,
   input logic           rst,
   hazard_stall_if.slave h
);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
   typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, IWAIT = 2'd2} state_e;
   state_e           state_q;
   logic [WD_W-1:0]  wd_q;
   logic             timeout_q;
   logic [CNT_W-1:0] cnt_q [4];
   logic             lu, dm, im, frz, fl, luh, imh;
   logic [3:0]       hit;
   always_comb begin
      lu  = h.ex_mem_read_i && h.ex_rt_i != 5'd0 &&
            ((h.id_uses_rs_i && h.id_rs_i == h.ex_rt_i) || (h.id_uses_rt_i && h.id_rt_i == h.ex_rt_i));
      dm  = h.dcache_req_i && !h.dcache_ready_i;
      im  = !h.icache_ready_i;
      frz = dm || (state_q == DWAIT && !h.dcache_ready_i);
      fl  = !frz && h.ex_mispredict_i;
      luh = !frz && !fl && lu;
      imh = !frz && !fl && !lu && im;
      hit = {imh, luh, fl, frz};
   end
   assign h.pc_stall_o       = frz || luh || imh;
   assign h.ifid_stall_o     = frz || luh;
   assign h.idex_stall_o     = frz;
   assign h.exmem_stall_o    = frz;
   assign h.memwb_flush_o    = frz;
   assign h.ifid_flush_o     = fl || imh;
   assign h.idex_flush_o     = fl || luh;
   assign h.dstall_timeout_o = timeout_q;
   assign h.cnt_dmiss_o      = cnt_q[0];
   assign h.cnt_flush_o      = cnt_q[1];
   assign h.cnt_load_use_o   = cnt_q[2];
   assign h.cnt_imiss_o      = cnt_q[3];
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         wd_q      <= '0;
         timeout_q <= 1'b0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         case (state_q)
            RUN:     state_q <= dm ? DWAIT : imh ? IWAIT : RUN;
            DWAIT:   state_q <= h.dcache_ready_i ? RUN : DWAIT;
            IWAIT:   state_q <= dm ? DWAIT : (h.icache_ready_i || h.ex_mispredict_i) ? RUN : IWAIT;
            default: state_q <= RUN;
         endcase
         // wd is zero on the first DWAIT cycle and parks at its limit so the error keeps re-arming
         wd_q      <= (state_q != DWAIT) ? '0 : (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
         timeout_q <= !h.perf_clr_i && (timeout_q || (state_q == DWAIT && wd_q == WD_MAX && !h.dcache_ready_i));
         for (int i = 0; i < 4; i++)
            cnt_q[i] <= h.perf_clr_i ? '0 : (hit[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
      end
   end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboarded directed + random check of the stall sequencer against a cycle-level model
module tb_hazard_stall_ctrl;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 8;
   localparam int MAXC    = (1 << CNT_W) - 1;
   typedef struct {
      logic [6:0] ctrl;
      int         cd, cf, cl, ci, to, st;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb [$];
   bit   m_dw, m_iw, m_to;
   int   m_dn;
   int   m_cnt [5];
   hazard_stall_if #(.CNT_W(CNT_W)) h ();
   hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .h(h));
   always #5 clk = ~clk;
   task automatic chk(input string n, input int a, input int x);
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, x);
      end
   endtask
   task automatic idle();
      h.id_rs_i = 5'd0; h.id_rt_i = 5'd0; h.id_uses_rs_i = 1'b0; h.id_uses_rt_i = 1'b0;
      h.ex_mem_read_i = 1'b0; h.ex_rt_i = 5'd0; h.icache_ready_i = 1'b1;
      h.dcache_req_i = 1'b0; h.dcache_ready_i = 1'b1; h.ex_mispredict_i = 1'b0;
      h.perf_clr_i = 1'b0; rst = 1'b0;
   endtask
   task automatic model_reset();
      m_dw = 0; m_iw = 0; m_to = 0; m_dn = 0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
   endtask
   // Expected outputs for the inputs now applied; then advance the model one cycle.
   task automatic cyc();
      exp_t e;
      bit   lu, dm, im;
      int   act;
      lu = h.ex_mem_read_i && h.ex_rt_i != 0 &&
           ((h.id_uses_rs_i && h.id_rs_i == h.ex_rt_i) || (h.id_uses_rt_i && h.id_rt_i == h.ex_rt_i));
      dm = h.dcache_req_i && !h.dcache_ready_i;
      im = !h.icache_ready_i;
      act = (dm || (m_dw && !h.dcache_ready_i)) ? 1 : h.ex_mispredict_i ? 2 : lu ? 3 : im ? 4 : 0;
      e.ctrl = {act == 1 || act == 3 || act == 4, act == 1 || act == 3, act == 1, act == 1,
                act == 2 || act == 4, act == 2 || act == 3, act == 1};
      e.cd = m_cnt[1]; e.cf = m_cnt[2]; e.cl = m_cnt[3]; e.ci = m_cnt[4];
      e.to = int'(m_to);
      e.st = m_dw ? 1 : m_iw ? 2 : 0;
      sb.push_back(e);
      if (rst) model_reset();
      else begin
         if (h.perf_clr_i) begin
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_to = 0;
         end else begin
            if (act != 0 && m_cnt[act] < MAXC) m_cnt[act]++;
            if (m_dw && m_dn + 1 >= TIMEOUT && !h.dcache_ready_i) m_to = 1;
         end
         if (m_dw) begin
            if (h.dcache_ready_i) m_dw = 0;
            else m_dn++;
         end else if (dm) begin
            m_dw = 1; m_iw = 0; m_dn = 0;
         end else if (m_iw) begin
            if (h.icache_ready_i || h.ex_mispredict_i) m_iw = 0;
         end else if (act == 4) m_iw = 1;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("ctrl", int'({h.pc_stall_o, h.ifid_stall_o, h.idex_stall_o, h.exmem_stall_o,
                           h.ifid_flush_o, h.idex_flush_o, h.memwb_flush_o}), int'(e.ctrl));
         chk("cnt_dmiss", int'(h.cnt_dmiss_o), e.cd);
         chk("cnt_flush", int'(h.cnt_flush_o), e.cf);
         chk("cnt_load_use", int'(h.cnt_load_use_o), e.cl);
         chk("cnt_imiss", int'(h.cnt_imiss_o), e.ci);
         chk("dstall_timeout", int'(h.dstall_timeout_o), e.to);
         chk("state", int'(dut.state_q), e.st);
      end
   end
   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc();
      // load-use with a real dependency, then against r0
      h.ex_mem_read_i = 1'b1; h.ex_rt_i = 5'd5; h.id_rs_i = 5'd5; h.id_uses_rs_i = 1'b1;
      cyc(); idle(); cyc();
      h.ex_mem_read_i = 1'b1; h.ex_rt_i = 5'd0; h.id_rs_i = 5'd0; h.id_uses_rs_i = 1'b1;
      cyc(); idle(); cyc();
      // D-miss for 4 cycles then release
      h.dcache_req_i = 1'b1; h.dcache_ready_i = 1'b0;
      run_n(4);
      h.dcache_ready_i = 1'b1;
      cyc(); idle(); run_n(2);
      // miss, mispredict and load-use together; mispredict wins on release
      h.dcache_req_i = 1'b1; h.dcache_ready_i = 1'b0; h.ex_mispredict_i = 1'b1;
      h.ex_mem_read_i = 1'b1; h.ex_rt_i = 5'd7; h.id_rt_i = 5'd7; h.id_uses_rt_i = 1'b1;
      run_n(2);
      h.dcache_ready_i = 1'b1;
      cyc(); idle(); cyc();
      // I-miss with mispredict in its second cycle
      h.icache_ready_i = 1'b0;
      cyc();
      h.ex_mispredict_i = 1'b1;
      cyc();
      h.ex_mispredict_i = 1'b0;
      cyc(); idle(); cyc();
      h.perf_clr_i = 1'b1;
      cyc(); idle(); cyc();
      // watchdog
      h.dcache_req_i = 1'b1; h.dcache_ready_i = 1'b0;
      run_n(10);
      h.dcache_ready_i = 1'b1;
      cyc(); idle(); run_n(2);
      h.perf_clr_i = 1'b1;
      cyc(); idle(); cyc();
      // saturation
      h.ex_mem_read_i = 1'b1; h.ex_rt_i = 5'd9; h.id_rt_i = 5'd9; h.id_uses_rt_i = 1'b1;
      run_n(20);
      idle(); cyc();
      // reset mid-DWAIT
      h.dcache_req_i = 1'b1; h.dcache_ready_i = 1'b0;
      run_n(3);
      rst = 1'b1;
      cyc(); idle(); run_n(2);
      for (int n = 0; n < 3000; n++) begin
         h.id_rs_i         = 5'($urandom_range(0, 3));
         h.id_rt_i         = 5'($urandom_range(0, 3));
         h.ex_rt_i         = 5'($urandom_range(0, 3));
         h.id_uses_rs_i    = 1'($urandom_range(0, 1));
         h.id_uses_rt_i    = 1'($urandom_range(0, 1));
         h.ex_mem_read_i   = 1'($urandom_range(0, 1));
         h.icache_ready_i  = $urandom_range(0, 99) < 80;
         h.dcache_req_i    = $urandom_range(0, 99) < 30;
         h.dcache_ready_i  = $urandom_range(0, 99) < 45;
         h.ex_mispredict_i = $urandom_range(0, 99) < 10;
         h.perf_clr_i      = $urandom_range(0, 99) < 3;
         rst               = $urandom_range(0, 199) < 2;
         cyc();
      end
      idle();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
